// File: rtl/adpll_seq.sv
// adpll_seq: bring-up sequencer that masters the adpll_ctr CPU bus.
// It programs the channel FCW, enables the ADPLL, polls lock status and
// reports lock, timeout or bad channel. It also performs a disable on request.
module adpll_seq #(
    parameter int unsigned             ADDR_W    = 5,
    parameter int unsigned             DATA_W    = 32,
    parameter int unsigned             FCW_ADDR  = 0,
    parameter int unsigned             EN_ADDR   = 1,
    parameter int unsigned             N_CH      = 40,
    parameter logic [DATA_W-1:0]       FCW_BASE  = 32'h0960_0000,
    parameter logic [DATA_W-1:0]       FCW_STEP  = 32'h0010_0000,
    parameter int unsigned             POLL_GAP  = 16,
    parameter int unsigned             MAX_POLLS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [5:0]        channel,
    output logic              busy,
    output logic              done,
    output logic              locked,
    output logic              timeout,
    output logic              bad_ch,
    output logic              m_valid,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_wstrb,
    input  logic [1:0]        m_rdata,
    input  logic              m_ready
);

    localparam int unsigned PW = $clog2(MAX_POLLS + 1);
    localparam int unsigned GW = $clog2(POLL_GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_FCW  = 3'd1,
        S_WR_EN   = 3'd2,
        S_GAP     = 3'd3,
        S_RD_LOCK = 3'd4,
        S_WR_DIS  = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [5:0]        ch_q;
    logic [5:0]        ch_nxt;
    logic [PW-1:0]     poll_cnt;
    logic [PW-1:0]     poll_nxt;
    logic [GW-1:0]     gap_cnt;
    logic [GW-1:0]     gap_nxt;
    logic              tmo_pend;
    logic              tmo_pend_nxt;

    logic              busy_nxt;
    logic              done_nxt;
    logic              locked_nxt;
    logic              timeout_nxt;
    logic              bad_ch_nxt;
    logic              m_valid_nxt;
    logic [ADDR_W-1:0] m_address_nxt;
    logic [DATA_W-1:0] m_wdata_nxt;
    logic              m_wstrb_nxt;

    logic              xfer;
    logic              ch_bad;
    logic              rd_lock;
    logic [PW-1:0]     poll_inc;
    logic              poll_last;
    logic              gap_last;
    logic [DATA_W-1:0] fcw_in;
    logic [DATA_W-1:0] fcw_q;

    // Shared decode: handshake, channel range, counters and FCW arithmetic
    always_comb begin
        xfer      = m_valid & m_ready;
        ch_bad    = (32'(channel) >= N_CH);
        rd_lock   = (m_rdata == 2'b01);
        poll_inc  = poll_cnt + PW'(1);
        poll_last = (poll_inc == PW'(MAX_POLLS));
        gap_last  = (gap_cnt == GW'(POLL_GAP - 1));
        fcw_in    = FCW_BASE + DATA_W'(channel) * FCW_STEP;
        fcw_q     = FCW_BASE + DATA_W'(ch_q) * FCW_STEP;
    end

    // State and all registered outputs/datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ch_q      <= '0;
            poll_cnt  <= '0;
            gap_cnt   <= '0;
            tmo_pend  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            locked    <= 1'b0;
            timeout   <= 1'b0;
            bad_ch    <= 1'b0;
            m_valid   <= 1'b0;
            m_address <= '0;
            m_wdata   <= '0;
            m_wstrb   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ch_q      <= ch_nxt;
            poll_cnt  <= poll_nxt;
            gap_cnt   <= gap_nxt;
            tmo_pend  <= tmo_pend_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            locked    <= locked_nxt;
            timeout   <= timeout_nxt;
            bad_ch    <= bad_ch_nxt;
            m_valid   <= m_valid_nxt;
            m_address <= m_address_nxt;
            m_wdata   <= m_wdata_nxt;
            m_wstrb   <= m_wstrb_nxt;
        end
    end

    // Next-state selection; stop has priority over start in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (stop) begin
                    state_nxt = S_WR_DIS;
                end else if (start && !ch_bad) begin
                    state_nxt = S_WR_FCW;
                end
            end
            S_WR_FCW: begin
                if (xfer) state_nxt = S_WR_EN;
            end
            S_WR_EN: begin
                if (xfer) state_nxt = S_GAP;
            end
            S_GAP: begin
                if (gap_last) state_nxt = S_RD_LOCK;
            end
            S_RD_LOCK: begin
                if (xfer) begin
                    if (rd_lock) begin
                        state_nxt = S_IDLE;
                    end else if (poll_last) begin
                        state_nxt = S_WR_DIS;
                    end else begin
                        state_nxt = S_GAP;
                    end
                end
            end
            S_WR_DIS: begin
                if (xfer) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of registered outputs, bus request and counters
    always_comb begin
        ch_nxt        = ch_q;
        poll_nxt      = poll_cnt;
        gap_nxt       = gap_cnt;
        tmo_pend_nxt  = tmo_pend;
        done_nxt      = 1'b0;
        locked_nxt    = locked;
        timeout_nxt   = timeout;
        bad_ch_nxt    = bad_ch;
        m_valid_nxt   = m_valid;
        m_address_nxt = m_address;
        m_wdata_nxt   = m_wdata;
        m_wstrb_nxt   = m_wstrb;

        case (state)
            S_IDLE: begin
                if (stop) begin
                    locked_nxt   = 1'b0;
                    tmo_pend_nxt = 1'b0;
                end else if (start) begin
                    ch_nxt      = channel;
                    locked_nxt  = 1'b0;
                    timeout_nxt = 1'b0;
                    bad_ch_nxt  = 1'b0;
                    if (ch_bad) begin
                        bad_ch_nxt = 1'b1;
                        done_nxt   = 1'b1;
                    end else begin
                        // FCW request leaves together with the state change
                        m_valid_nxt   = 1'b1;
                        m_address_nxt = ADDR_W'(FCW_ADDR);
                        m_wdata_nxt   = fcw_in;
                        m_wstrb_nxt   = 1'b1;
                    end
                end
            end
            S_WR_FCW: begin
                if (xfer) begin
                    m_valid_nxt = 1'b0;
                end else if (!m_valid) begin
                    m_valid_nxt   = 1'b1;
                    m_address_nxt = ADDR_W'(FCW_ADDR);
                    m_wdata_nxt   = fcw_q;
                    m_wstrb_nxt   = 1'b1;
                end
            end
            S_WR_EN: begin
                if (xfer) begin
                    m_valid_nxt = 1'b0;
                    poll_nxt    = '0;
                    gap_nxt     = '0;
                end else if (!m_valid) begin
                    m_valid_nxt   = 1'b1;
                    m_address_nxt = ADDR_W'(EN_ADDR);
                    m_wdata_nxt   = DATA_W'(1);
                    m_wstrb_nxt   = 1'b1;
                end
            end
            S_GAP: begin
                gap_nxt = gap_last ? '0 : gap_cnt + GW'(1);
            end
            S_RD_LOCK: begin
                if (xfer) begin
                    m_valid_nxt = 1'b0;
                    poll_nxt    = poll_inc;
                    gap_nxt     = '0;
                    if (rd_lock) begin
                        locked_nxt = 1'b1;
                        done_nxt   = 1'b1;
                    end else if (poll_last) begin
                        // timeout is reported together with the done of the disable
                        tmo_pend_nxt = 1'b1;
                    end
                end else if (!m_valid) begin
                    m_valid_nxt   = 1'b1;
                    m_address_nxt = ADDR_W'(EN_ADDR);
                    m_wdata_nxt   = '0;
                    m_wstrb_nxt   = 1'b0;
                end
            end
            S_WR_DIS: begin
                if (xfer) begin
                    m_valid_nxt  = 1'b0;
                    done_nxt     = 1'b1;
                    timeout_nxt  = tmo_pend;
                    tmo_pend_nxt = 1'b0;
                end else if (!m_valid) begin
                    m_valid_nxt   = 1'b1;
                    m_address_nxt = ADDR_W'(EN_ADDR);
                    m_wdata_nxt   = '0;
                    m_wstrb_nxt   = 1'b1;
                end
            end
            default: begin
                m_valid_nxt = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_adpll_seq.sv
// tb_adpll_seq: directed vector bench for adpll_seq with a reactive bus slave.
module tb_adpll_seq;

    localparam int unsigned G    = 3;
    localparam int unsigned MAXP = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [5:0]  channel;
    logic        busy;
    logic        done;
    logic        locked;
    logic        timeout;
    logic        bad_ch;
    logic        m_valid;
    logic [4:0]  m_address;
    logic [31:0] m_wdata;
    logic        m_wstrb;
    logic [1:0]  m_rdata;
    logic        m_ready;

    adpll_seq #(
        .ADDR_W(5), .DATA_W(32), .FCW_ADDR(0), .EN_ADDR(1), .N_CH(40),
        .FCW_BASE(32'h0960_0000), .FCW_STEP(32'h0010_0000),
        .POLL_GAP(G), .MAX_POLLS(MAXP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .channel(channel),
        .busy(busy), .done(done), .locked(locked), .timeout(timeout),
        .bad_ch(bad_ch), .m_valid(m_valid), .m_address(m_address),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
        .m_ready(m_ready)
    );

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        wstrb;
    } tx_t;

    typedef struct {
        logic [5:0]  ch;
        int          rdy_max;
        int          lock_after;
        logic [31:0] fcw;
        int          n_reads;
        logic        e_locked;
        logic        e_timeout;
        logic        e_bad;
        int          e_lat;
    } vec_t;

    tx_t txlog[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  rd_cnt = 0;
    int  lock_after = 0;
    int  ready_max = 0;
    int  stab_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic tx_t mk(input logic [4:0] a, input logic [31:0] d, input logic w);
        tx_t t;
        t = '{addr: a, data: d, wstrb: w};
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus slave: random ready delay, logs completed transactions, checks hold stability
    initial begin : slave
        int   wait_cnt;
        logic active;
        tx_t  cap;
        tx_t  cur;
        wait_cnt = 0;
        active   = 1'b0;
        cap      = '0;
        m_ready  = 1'b0;
        m_rdata  = 2'b01;
        forever begin
            @(negedge clk);
            cur = mk(m_address, m_wdata, m_wstrb);
            if (rst) begin
                m_ready = 1'b0;
                m_rdata = 2'b01;
                active  = 1'b0;
            end else if (m_ready) begin
                m_ready = 1'b0;
                m_rdata = 2'b01;
            end else if (m_valid) begin
                if (!active) begin
                    active   = 1'b1;
                    cap      = cur;
                    wait_cnt = int'($urandom_range(ready_max, 0));
                end else if (cap != cur) begin
                    stab_err++;
                end
                if (wait_cnt == 0) begin
                    m_ready = 1'b1;
                    if (!m_wstrb) begin
                        rd_cnt++;
                        m_rdata = (lock_after != 0 && rd_cnt >= lock_after) ? 2'b01 : 2'b00;
                    end
                    txlog.push_back(cur);
                    active = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Apply one request and observe done latency and pulse count for a bounded window
    task automatic apply(input logic st, input logic sp, input logic [5:0] ch,
                         output int lat, output int npulse, output logic busy1);
        int k;
        @(negedge clk);
        start   = st;
        stop    = sp;
        channel = ch;
        @(negedge clk);
        start  = 1'b0;
        stop   = 1'b0;
        busy1  = busy;
        k      = 1;
        lat    = -1;
        npulse = 0;
        while (k < 2000 && (lat < 0 || k < lat + 10)) begin
            if (done) begin
                npulse++;
                if (lat < 0) lat = k;
            end
            @(negedge clk);
            k++;
        end
    endtask

    vec_t vecs[7];

    initial begin : main
        tx_t  exp_q[$];
        int   lat;
        int   np;
        int   mism;
        logic b1;

        vecs[0] = '{6'd0,  0, 3, 32'h0960_0000, 3, 1'b1, 1'b0, 1'b0, 19};
        vecs[1] = '{6'd39, 0, 1, 32'h0BD0_0000, 1, 1'b1, 1'b0, 1'b0, 9};
        vecs[2] = '{6'd40, 0, 1, 32'h0000_0000, 0, 1'b0, 1'b0, 1'b1, 1};
        vecs[3] = '{6'd5,  0, 0, 32'h09B0_0000, 4, 1'b0, 1'b1, 1'b0, 26};
        vecs[4] = '{6'd0,  5, 3, 32'h0960_0000, 3, 1'b1, 1'b0, 1'b0, -1};
        vecs[5] = '{6'd63, 0, 1, 32'h0000_0000, 0, 1'b0, 1'b0, 1'b1, 1};
        vecs[6] = '{6'd12, 5, 0, 32'h0A20_0000, 4, 1'b0, 1'b1, 1'b0, -1};

        rst     = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        channel = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            64'({busy, done, locked, timeout, bad_ch, m_valid, m_wstrb, m_address, m_wdata}), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            txlog.delete();
            exp_q.delete();
            rd_cnt     = 0;
            stab_err   = 0;
            lock_after = vecs[v].lock_after;
            ready_max  = vecs[v].rdy_max;
            apply(1'b1, 1'b0, vecs[v].ch, lat, np, b1);

            if (!vecs[v].e_bad) begin
                exp_q.push_back(mk(5'd0, vecs[v].fcw, 1'b1));
                exp_q.push_back(mk(5'd1, 32'd1, 1'b1));
                for (int r = 0; r < vecs[v].n_reads; r++) exp_q.push_back(mk(5'd1, 32'd0, 1'b0));
                if (vecs[v].e_timeout) exp_q.push_back(mk(5'd1, 32'd0, 1'b1));
            end

            chk($sformatf("v%0d_done_pulses", v), 64'(np), 64'd1);
            if (vecs[v].e_lat >= 0) chk($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].e_lat));
            chk($sformatf("v%0d_busy_c1", v), 64'(b1), 64'(!vecs[v].e_bad));
            chk($sformatf("v%0d_locked", v), 64'(locked), 64'(vecs[v].e_locked));
            chk($sformatf("v%0d_timeout", v), 64'(timeout), 64'(vecs[v].e_timeout));
            chk($sformatf("v%0d_bad_ch", v), 64'(bad_ch), 64'(vecs[v].e_bad));
            chk($sformatf("v%0d_busy_end", v), 64'(busy), 64'd0);
            chk($sformatf("v%0d_tx_count", v), 64'(txlog.size()), 64'(exp_q.size()));
            mism = 0;
            for (int i = 0; i < txlog.size() && i < exp_q.size(); i++) begin
                if (txlog[i] !== exp_q[i]) mism++;
            end
            chk($sformatf("v%0d_tx_mismatches", v), 64'(mism), 64'd0);
            chk($sformatf("v%0d_hold_stable", v), 64'(stab_err), 64'd0);
        end

        // Locked, then simultaneous start and stop: only a disable write
        txlog.delete();
        rd_cnt     = 0;
        lock_after = 1;
        ready_max  = 0;
        apply(1'b1, 1'b0, 6'd1, lat, np, b1);
        chk("pre_sim_locked", 64'(locked), 64'd1);
        txlog.delete();
        apply(1'b1, 1'b1, 6'd2, lat, np, b1);
        chk("sim_done_pulses", 64'(np), 64'd1);
        chk("sim_latency", 64'(lat), 64'd3);
        chk("sim_locked", 64'(locked), 64'd0);
        chk("sim_tx_count", 64'(txlog.size()), 64'd1);
        if (txlog.size() >= 1) chk("sim_tx", 64'(txlog[0]), 64'(mk(5'd1, 32'd0, 1'b1)));

        // Reset while waiting between polls
        txlog.delete();
        rd_cnt     = 0;
        lock_after = 0;
        @(negedge clk);
        start   = 1'b1;
        channel = 6'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("gap_busy", 64'(busy), 64'd1);
        chk("gap_address", 64'(m_address), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outputs",
            64'({busy, done, locked, timeout, bad_ch, m_valid, m_wstrb, m_address, m_wdata}), 64'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_tx_count", 64'(txlog.size()), 64'd2);
        chk("midrst_idle", 64'({busy, m_valid}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
